spi_responder: RTL
==================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter CPOL, default 1, SPI_CLK idle level.
REQ-002 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 SPI_CLK  input  1  serial clock from the SPI driver; asynchronous to clk.
REQ-006 SPI_EN  input  1  active-high select from the driver; asynchronous.
REQ-007 SPI_MOSI  input  1  serial data in, MSB first; asynchronous.
REQ-008 SPI_MISO  output  1  serial data out, MSB first.
REQ-009 tx_data  input  8  next byte to transmit.
REQ-010 tx_load  input  1  write strobe for tx_data; honoured only while tx_ready=1.
REQ-011 tx_ready  output  1  high when the transmit buffer is empty.
REQ-012 data_out  output  8  last fully received byte.
REQ-013 rx_valid  output  1  one-cycle pulse when data_out updates.
REQ-014 rx_abort  output  1  one-cycle pulse when SPI_EN drops mid-byte.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SPI_CLK, SPI_EN and SPI_MOSI SHALL each pass through a 2-flop synchronizer; a third SPI_CLK flop SHALL provide edge detection.
REQ-017 Leading edge = synchronized SPI_CLK leaving CPOL; trailing edge = returning to CPOL; sample edge per REQ-002; the other edge is the shift edge.
REQ-018 State machine: IDLE, LOAD, SHIFT, DONE.
REQ-019 IDLE -> LOAD on synchronized SPI_EN rising; LOAD lasts one cycle: shift-out register <= tx buffer if full (tx_ready -> 1), else 8'h00; bit counter <= 0.
REQ-020 LOAD, CPHA=0: SPI_MISO <= bit 7 of shift-out register in the same cycle; CPHA=1: SPI_MISO updates to bit 7 on the first shift edge.
REQ-021 SHIFT: each sample edge shifts synchronized MOSI into the receive register LSB and increments the 3-bit counter; each shift edge (excluding the first edge of a byte when CPHA=0) presents the next bit on SPI_MISO.
REQ-022 8th sample edge -> DONE; DONE lasts one cycle: data_out <= received byte, rx_valid=1; next state LOAD if SPI_EN still high, else IDLE.
REQ-023 rx_valid SHALL assert exactly 3 clk cycles after the clk edge that first samples the 8th sample edge on the SPI_CLK pin.
REQ-024 SPI_EN falling in LOAD or SHIFT with counter < 8 -> IDLE next cycle, rx_abort=1 for one cycle, data_out unchanged, no rx_valid.
REQ-025 SPI_EN falling in the DONE cycle: rx_valid still pulses, next state IDLE, no rx_abort.
REQ-026 SPI_MISO SHALL be 0 whenever the state is IDLE.
REQ-027 tx_load with tx_ready=1 captures tx_data and clears tx_ready next cycle; tx_load with tx_ready=0 SHALL be ignored; tx_load in the same cycle the LOAD state empties the buffer SHALL be ignored.
REQ-028 Correct operation requires SPI_CLK high and low phases each >= 4 clk cycles and SPI_EN setup before the first edge >= 4 clk cycles; behaviour outside these limits is undefined.

Reset
REQ-029 rst=1 at a clk edge SHALL force state IDLE, SPI_MISO=0, data_out=8'h00, rx_valid=0, rx_abort=0, busy=0, tx_ready=1, counter=0, synchronizer flops=CPOL (clock) / 0 (others).
REQ-030 Reset mid-byte SHALL discard partial data without pulsing rx_abort.

Verification
REQ-031 CPOL=1, CPHA=0, tx_load 8'hA5; driver sends 8'h3C with SPI_CLK half-period 8 clk -> data_out=8'h3C, one rx_valid pulse, MISO bit sequence 1,0,1,0,0,1,0,1, tx_ready=1 afterwards.
REQ-032 CPOL=0, CPHA=1, no tx_load; driver sends 8'hFF -> data_out=8'hFF, MISO all 0.
REQ-033 Two back-to-back bytes 8'h12, 8'h34 under one SPI_EN assertion, tx_load 8'h55 between them -> rx_valid pulses twice with data_out 8'h12 then 8'h34; second byte's MISO = 8'h55.
REQ-034 SPI_EN dropped after 5 sample edges -> rx_abort one pulse, no rx_valid, data_out keeps prior value, state IDLE, MISO=0.
REQ-035 rst asserted after 3 bits -> all outputs at REQ-029 values the next cycle; a following full transfer of 8'hC3 is received correctly.
REQ-036 tx_load asserted twice while tx_ready=0 -> second value ignored; first loaded byte transmitted.

Source files
------------

// File: rtl/spi_responder.sv
// spi_responder: SPI target (slave) that receives one byte per 8 sample edges
// and transmits a byte from a single-entry transmit buffer. All SPI pins are
// asynchronous to clk and are resynchronised before use.
//
// Parameters
//   CPOL      SPI_CLK idle level
//   CPHA      0 = sample on leading edge, 1 = sample on trailing edge
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   SPI_CLK   serial clock from the driver (async)
//   SPI_EN    active-high select from the driver (async)
//   SPI_MOSI  serial data in, MSB first (async)
//   SPI_MISO  serial data out, MSB first; 0 while idle
//   tx_data   next byte to transmit
//   tx_load   write strobe for tx_data, honoured only while tx_ready=1
//   tx_ready  high when the transmit buffer is empty
//   data_out  last fully received byte
//   rx_valid  one-cycle pulse when data_out updates
//   rx_abort  one-cycle pulse when SPI_EN drops mid-byte
//   busy      high whenever the state machine is not idle
module spi_responder #(
  parameter logic CPOL = 1'b1,
  parameter logic CPHA = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_CLK,
  input  logic       SPI_EN,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_abort,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        sclk_s1_r, sclk_s2_r, sclk_s3_r;
  logic        en_s1_r, en_s2_r, en_d_r;
  logic        mosi_s1_r, mosi_s2_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  rx_shift_r;
  logic [7:0]  tx_shift_r;
  logic [7:0]  tx_buf_r;

  logic        lead_s, trail_s, sample_s, shift_s, en_rise_s;
  logic [7:0]  load_byte_s;

  // Two-flop synchronisers on all SPI pins, third clock flop and enable delay for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1_r <= CPOL;
      sclk_s2_r <= CPOL;
      sclk_s3_r <= CPOL;
      en_s1_r   <= 1'b0;
      en_s2_r   <= 1'b0;
      en_d_r    <= 1'b0;
      mosi_s1_r <= 1'b0;
      mosi_s2_r <= 1'b0;
    end else begin
      sclk_s1_r <= SPI_CLK;
      sclk_s2_r <= sclk_s1_r;
      sclk_s3_r <= sclk_s2_r;
      en_s1_r   <= SPI_EN;
      en_s2_r   <= en_s1_r;
      en_d_r    <= en_s2_r;
      mosi_s1_r <= SPI_MOSI;
      mosi_s2_r <= mosi_s1_r;
    end
  end

  // Edge classification and the byte that LOAD hands to the shifter
  always_comb begin
    lead_s    = (sclk_s2_r != CPOL) && (sclk_s3_r == CPOL);
    trail_s   = (sclk_s2_r == CPOL) && (sclk_s3_r != CPOL);
    en_rise_s = en_s2_r && !en_d_r;
    if (CPHA == 1'b0) begin
      sample_s = lead_s;
      shift_s  = trail_s;
    end else begin
      sample_s = trail_s;
      shift_s  = lead_s;
    end
    if (tx_ready) begin
      load_byte_s = 8'h00;
    end else begin
      load_byte_s = tx_buf_r;
    end
  end

  // Transfer state machine, transmit buffer and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      SPI_MISO   <= 1'b0;
      data_out   <= 8'h00;
      rx_valid   <= 1'b0;
      rx_abort   <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      tx_buf_r   <= 8'h00;
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 8'h00;
      tx_shift_r <= 8'h00;
    end else begin
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      // A LOAD that empties the buffer below overrides this in the same cycle.
      if (tx_load && tx_ready) begin
        tx_buf_r <= tx_data;
        tx_ready <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          SPI_MISO  <= 1'b0;
          bit_cnt_r <= 3'd0;
          if (en_rise_s) begin
            state_r <= LOAD;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        LOAD: begin
          if (!en_s2_r) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            SPI_MISO <= 1'b0;
            rx_abort <= 1'b1;
          end else begin
            state_r   <= SHIFT;
            bit_cnt_r <= 3'd0;
            if (!tx_ready) begin
              tx_ready <= 1'b1;
            end
            // CPHA=0 must present bit 7 before the first (sampling) edge.
            if (CPHA == 1'b0) begin
              SPI_MISO   <= load_byte_s[7];
              tx_shift_r <= {load_byte_s[6:0], 1'b0};
            end else begin
              tx_shift_r <= load_byte_s;
            end
          end
        end
        SHIFT: begin
          if (!en_s2_r) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            SPI_MISO <= 1'b0;
            rx_abort <= 1'b1;
          end else begin
            if (sample_s) begin
              rx_shift_r <= {rx_shift_r[6:0], mosi_s2_r};
              bit_cnt_r  <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= DONE;
              end
            end
            // With CPHA=0 the trailing edge of the previous byte's last bit
            // arrives after LOAD; it must not advance the new byte.
            if (shift_s && (CPHA || (bit_cnt_r != 3'd0))) begin
              SPI_MISO   <= tx_shift_r[7];
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            end
          end
        end
        DONE: begin
          data_out <= rx_shift_r;
          rx_valid <= 1'b1;
          if (en_s2_r) begin
            state_r <= LOAD;
            busy    <= 1'b1;
          end else begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            SPI_MISO <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          busy     <= 1'b0;
          SPI_MISO <= 1'b0;
        end
      endcase
    end
  end

endmodule
